// File: rtl/program_run_controller.sv
// Run sequencer: accepts a four-phase req, launches the core at a table-selected
// entry PC, gates execution, and acks on done-PC match or cycle-limit timeout.
module program_run_controller #(
  parameter int PC_BITS      = 10,
  parameter int NUM_PROGRAMS = 4,
  parameter int CNT_BITS     = 16,
  parameter int MAX_CYCLES   = 50000,
  parameter int DEFAULT_DONE = 435,
  localparam int SEL_BITS    = $clog2(NUM_PROGRAMS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req,
  input  logic [SEL_BITS-1:0] prog_sel,
  input  logic [PC_BITS-1:0]  pc,
  input  logic                cfg_we,
  input  logic [SEL_BITS-1:0] cfg_idx,
  input  logic [PC_BITS-1:0]  cfg_start,
  input  logic [PC_BITS-1:0]  cfg_done,
  output logic                core_start,
  output logic [PC_BITS-1:0]  start_pc,
  output logic                run_en,
  output logic                busy,
  output logic                ack,
  output logic                timeout,
  output logic [CNT_BITS-1:0] cycle_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [PC_BITS-1:0]  default_done = PC_BITS'(DEFAULT_DONE);
  localparam logic [CNT_BITS-1:0] max_count    = CNT_BITS'(MAX_CYCLES);

  state_t              state;
  logic [SEL_BITS-1:0] sel_reg;
  logic [PC_BITS-1:0]  start_tab [NUM_PROGRAMS];
  logic [PC_BITS-1:0]  done_tab  [NUM_PROGRAMS];

  // Table is writable only in IDLE, so the latched entry is stable for a whole run.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_PROGRAMS; i++) begin
        start_tab[i] <= '0;
        done_tab[i]  <= default_done;
      end
    end else if (cfg_we && state == IDLE) begin
      start_tab[cfg_idx] <= cfg_start;
      done_tab[cfg_idx]  <= cfg_done;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      sel_reg     <= '0;
      core_start  <= 1'b0;
      start_pc    <= '0;
      run_en      <= 1'b0;
      busy        <= 1'b0;
      ack         <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A same-cycle table write takes precedence; the run starts next cycle.
          if (req && !cfg_we) begin
            sel_reg     <= prog_sel;
            start_pc    <= start_tab[prog_sel];
            cycle_count <= '0;
            timeout     <= 1'b0;
            core_start  <= 1'b1;
            busy        <= 1'b1;
            state       <= LAUNCH;
          end
        end
        LAUNCH: begin
          core_start <= 1'b0;
          run_en     <= 1'b1;
          state      <= RUN;
        end
        RUN: begin
          cycle_count <= cycle_count + 1'b1;
          if (!req) begin
            run_en <= 1'b0;
            busy   <= 1'b0;
            state  <= IDLE;
          end else if (pc == done_tab[sel_reg]) begin
            run_en  <= 1'b0;
            ack     <= 1'b1;
            timeout <= 1'b0;
            state   <= DONE;
          end else if (cycle_count + 1'b1 == max_count) begin
            run_en  <= 1'b0;
            ack     <= 1'b1;
            timeout <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (!req) begin
            ack   <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
